bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Parametrised branch history table (BHT) for the RISC-V fetch stage.
- Replaces the single global 2-bit predictor with 2^INDEX_BITS saturating counters, each selected by PC bits.
- Fetch gets a combinational taken/not-taken prediction plus the table index it used.
- Execute returns that index with the resolved outcome; the block then trains the counter and counts mispredictions.

Parameters:
- PC_W, 32, width of program counter.
- INDEX_BITS, 6, log2 of table depth (default 64 entries).
- CTR_BITS, 2, saturating counter width; 2..4 legal.
- INIT_CTR, 0, counter value loaded at reset (0 = strongly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pred_pc  in  PC_W  PC of the instruction being fetched.
- pred_taken  out  1  prediction for pred_pc; 1 = taken.
- pred_idx  out  INDEX_BITS  table index used; pipeline carries it to execute.
- upd_valid  in  1  a branch resolved this cycle (branch qualifier).
- upd_idx  in  INDEX_BITS  pred_idx value captured at fetch for that branch.
- upd_taken  in  1  actual outcome (PCSrc).
- upd_pred  in  1  prediction that was made for that branch.
- mispredict_count  out  32  saturating count of mispredicted branches.

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - All counters load INIT_CTR.
  - mispredict_count = 0.
  - GHR = 0 (when present).
  - pred_taken = MSB of INIT_CTR (0 by default).
- Index, combinational: base index = pred_pc[INDEX_BITS+1:2]. Bits [1:0] are ignored because instructions are word-aligned.
- Prediction, combinational, zero latency: pred_taken = MSB of the counter at pred_idx.
  - With CTR_BITS=2: 00 SNT and 01 WNT predict 0; 10 WT and 11 ST predict 1.
- Update, registered on posedge clk when upd_valid=1:
  - upd_taken=1: counter[upd_idx] increments, saturating at 2^CTR_BITS-1.
  - upd_taken=0: counter decrements, saturating at 0.
  - With CTR_BITS=2 this gives SNT->WNT->WT->ST on taken and ST->WT->WNT->SNT on not-taken.
- upd_valid=0: table and count hold.
- Misprediction count: when upd_valid=1 and upd_taken!=upd_pred, mispredict_count increments. It saturates at 32'hFFFF_FFFF and does not wrap.
- Read/write collision: pred_idx==upd_idx in the same cycle returns the pre-update counter value. There is no bypass; the new value is visible the next cycle.
- Only one update per cycle. No other counter changes on an update.
- Reset mid-operation: all state clears immediately. An update coinciding with rst is dropped.
- upd_idx is used verbatim and never recomputed from a PC, so predict and train always hit the same entry.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - Adds an INDEX_BITS-wide global history register (GHR).
  - pred_idx = base index XOR GHR.
  - On upd_valid, GHR <= {GHR[INDEX_BITS-2:0], upd_taken}. This is non-speculative, training-time history.
  - Collision rule for the table is unchanged; prediction uses the pre-shift GHR.
  - Adds output port ghr_out (out, INDEX_BITS) for debug.
- Undefined:
  - pred_idx = base index, pure bimodal.
  - No GHR flops and no ghr_out port.

Decomposition:
- Package bht_pkg holds:
  - Counter-state constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11, for CTR_BITS=2.
  - Function sat_update(ctr, taken, width).
  - Index-extraction helper.
- One sub-module, bht_sat_counter:
  - Single CTR_BITS saturating counter with enable and taken inputs and an async reset to INIT_CTR.
  - Instantiated 2^INDEX_BITS times by a generate loop.
  - Top level holds the read mux, index logic, GHR and misprediction counter.

Test Plan:
- Reset then pred_pc=0x0000_0040 -> pred_taken=0, pred_idx=16, mispredict_count=0.
- Four updates to idx 16 with taken=1, upd_pred=0 -> counter goes 00,01,10,11,11. pred_taken=1 from after the 2nd update. mispredict_count=4.
- From ST, one not-taken update on idx 16 -> WT, pred_taken stays 1. A second not-taken update -> WNT, pred_taken=0.
- Same cycle pred_pc=0x40 and upd_valid, upd_idx=16, upd_taken=1, starting from WNT -> pred_taken=0 this cycle, 1 the next cycle. idx 17 is unchanged.
- Force mispredict_count to 32'hFFFF_FFFE, apply 3 mispredictions -> reads 32'hFFFF_FFFF, no wrap. Assert rst mid-stream -> count=0 and all indices predict 0 immediately.
- With BHT_GSHARE_EN: three taken updates -> ghr_out=6'b000111. Then pred_pc=0x40 -> pred_idx=16^7=23. An update on idx 23 leaves idx 16 unchanged.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: counter-state names,
// the saturating counter step and the PC-to-index helper.
package bht_pkg;

  // Named states of a 2-bit counter (strongly/weakly not-taken/taken)
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Widest counter the helpers handle; callers cast to their own width
  localparam int CTR_MAX_W = 4;

  // One training step of a width-bit saturating counter
  function automatic logic [CTR_MAX_W-1:0] sat_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int                   width
  );
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << width) - 1);
    if (taken) begin
      return (ctr >= top) ? top : ctr + 1'b1;
    end else begin
      return (ctr == '0) ? '0 : ctr - 1'b1;
    end
  endfunction

  // Word-aligned PC to table index: drop bits [1:0], keep the next 'bits' bits
  function automatic logic [31:0] base_index(
    input logic [31:0] pc,
    input int          bits
  );
    return (pc >> 2) & ((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// One saturating branch counter; trains on en, resets asynchronously to INIT_CTR.
module bht_sat_counter
  import bht_pkg::*;
#(
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr
);

  // Counter register: step toward taken/not-taken when selected for training
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= CTR_BITS'(INIT_CTR);
    end else if (en) begin
      ctr <= CTR_BITS'(sat_update(CTR_MAX_W'(ctr), taken, CTR_BITS));
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table for the fetch stage.
// Fetch reads a zero-latency prediction and the index it used; execute hands
// that index back with the resolved outcome to train the selected counter.
// Build option: define BHT_GSHARE_EN to XOR a training-time global history
// register into the index and expose it on ghr_out.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int INIT_CTR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_W-1:0]       pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_pred,
`ifdef BHT_GSHARE_EN
  output logic [INDEX_BITS-1:0] ghr_out,
`endif
  output logic [31:0]           mispredict_count
);

  localparam int NUM_ENTRIES = 1 << INDEX_BITS;

  // Count one more misprediction without wrapping past all-ones
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  logic [INDEX_BITS-1:0] base_idx;
  logic [CTR_BITS-1:0]   ctr_q [NUM_ENTRIES];
  logic [31:0]           mispred_cnt;
  logic                  mispredicted;

  // Base index straight from the word-aligned PC
  always_comb begin
    base_idx = INDEX_BITS'(base_index(32'(pred_pc), INDEX_BITS));
  end

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;

  // Global history shifts in resolved outcomes only, so it never needs repair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= INDEX_BITS'({ghr_q, upd_taken});
    end
  end

  // Hash the PC with pre-shift history; execute returns this exact index
  always_comb begin
    pred_idx = base_idx ^ ghr_q;
    ghr_out  = ghr_q;
  end
`else
  // Pure bimodal indexing
  always_comb begin
    pred_idx = base_idx;
  end
`endif

  // Counter array: only the entry named by upd_idx trains on an update
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ctr
    bht_sat_counter #(
      .CTR_BITS (CTR_BITS),
      .INIT_CTR (INIT_CTR)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (upd_valid && (upd_idx == INDEX_BITS'(i))),
      .taken (upd_taken),
      .ctr   (ctr_q[i])
    );
  end

  // Read mux: counter MSB is the prediction; same-cycle updates are not bypassed
  always_comb begin
    pred_taken = ctr_q[pred_idx][CTR_BITS-1];
  end

  // A resolved branch whose outcome differs from what fetch predicted
  always_comb begin
    mispredicted = upd_valid && (upd_taken != upd_pred);
  end

  // Misprediction counter, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (mispredicted) begin
      mispred_cnt <= sat_inc32(mispred_cnt);
    end
  end

  // Expose the misprediction count
  always_comb begin
    mispredict_count = mispred_cnt;
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor against a behavioural table model.
module tb_bht_predictor;

  localparam int PC_W       = 32;
  localparam int INDEX_BITS = 6;
  localparam int CTR_BITS   = 2;
  localparam int INIT_CTR   = 0;
  localparam int N          = 1 << INDEX_BITS;
  localparam int CMAX       = (1 << CTR_BITS) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [PC_W-1:0]       pred_pc = '0;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_idx;
  logic                  upd_valid = 1'b0;
  logic [INDEX_BITS-1:0] upd_idx = '0;
  logic                  upd_taken = 1'b0;
  logic                  upd_pred = 1'b0;
  logic [31:0]           mispredict_count;
`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_out;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  int     ctr_m [N];
  longint cnt_m;
  int     ghr_m;

  bht_predictor #(
    .PC_W       (PC_W),
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .INIT_CTR   (INIT_CTR)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_idx         (pred_idx),
    .upd_valid        (upd_valid),
    .upd_idx          (upd_idx),
    .upd_taken        (upd_taken),
    .upd_pred         (upd_pred),
`ifdef BHT_GSHARE_EN
    .ghr_out          (ghr_out),
`endif
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) ctr_m[i] = INIT_CTR;
    cnt_m = 0;
    ghr_m = 0;
  endfunction

  function automatic int model_idx(input logic [31:0] pc);
    return (int'(pc / 4) % N) ^ ghr_m;
  endfunction

  function automatic bit model_pred(input int idx);
    return ctr_m[idx] >= (CMAX + 1) / 2;
  endfunction

  function automatic void model_update(input int idx, input bit taken, input bit pred);
    if (taken) ctr_m[idx] = (ctr_m[idx] == CMAX) ? CMAX : ctr_m[idx] + 1;
    else       ctr_m[idx] = (ctr_m[idx] == 0) ? 0 : ctr_m[idx] - 1;
    if (taken != pred && cnt_m < 64'hFFFF_FFFF) cnt_m = cnt_m + 1;
`ifdef BHT_GSHARE_EN
    ghr_m = ((ghr_m * 2) + int'(taken)) % N;
`endif
  endfunction

  // A PC whose prediction lands on table entry idx under the current history
  function automatic logic [31:0] pc_for(input int idx);
    return 32'((idx ^ ghr_m) * 4);
  endfunction

  // Present one update for one clock edge and advance the model with it
  task automatic drive_update(input bit t, input int idx, input bit p);
    @(negedge clk);
    upd_valid = 1'b1;
    upd_idx   = INDEX_BITS'(idx);
    upd_taken = t;
    upd_pred  = p;
    @(posedge clk);
    model_update(idx, t, p);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pred_pc = 32'h0000_0040;
    #2;
    checks++;
    if (pred_taken !== 1'b0 || mispredict_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_in_rst: pred_taken=%0b count=%0d expected 0/0", pred_taken, mispredict_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pred_idx !== 6'd16) begin
      failures++;
      $display("FAIL reset_idx: got %0d expected 16", pred_idx);
    end
    checks++;
    if (pred_taken !== 1'b0 || mispredict_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: pred_taken=%0b count=%0d expected 0/0", pred_taken, mispredict_count);
    end
  endtask

  task automatic test_train_taken();
    int exp_ctr [4] = '{1, 2, 3, 3};
    for (int k = 0; k < 4; k++) begin
      drive_update(1'b1, 16, 1'b0);
      @(negedge clk);
      pred_pc = pc_for(16);
      #1;
      checks++;
      if (int'(dut.ctr_q[16]) !== exp_ctr[k]) begin
        failures++;
        $display("FAIL taken_ctr[%0d]: got %0d expected %0d", k, dut.ctr_q[16], exp_ctr[k]);
      end
      checks++;
      if (pred_idx !== 6'd16 || pred_taken !== (k >= 1)) begin
        failures++;
        $display("FAIL taken_pred[%0d]: idx=%0d taken=%0b expected 16/%0b", k, pred_idx, pred_taken, k >= 1);
      end
      checks++;
      if (mispredict_count !== 32'(k + 1)) begin
        failures++;
        $display("FAIL taken_count[%0d]: got %0d expected %0d", k, mispredict_count, k + 1);
      end
    end
  endtask

  task automatic test_train_not_taken();
    bit exp_pred [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      drive_update(1'b0, 16, 1'b1);
      @(negedge clk);
      pred_pc = pc_for(16);
      #1;
      checks++;
      if (pred_taken !== exp_pred[k] || pred_taken !== model_pred(16)) begin
        failures++;
        $display("FAIL nt_pred[%0d]: got %0b expected %0b", k, pred_taken, exp_pred[k]);
      end
      checks++;
      if (64'(mispredict_count) !== cnt_m) begin
        failures++;
        $display("FAIL nt_count[%0d]: got %0d expected %0d", k, mispredict_count, cnt_m);
      end
    end
  endtask

  task automatic test_collision();
    // entry 16 sits at weakly not-taken here
    @(negedge clk);
    pred_pc   = pc_for(16);
    upd_valid = 1'b1;
    upd_idx   = 6'd16;
    upd_taken = 1'b1;
    upd_pred  = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL collision_same_cycle: got %0b expected 0", pred_taken);
    end
    @(posedge clk);
    model_update(16, 1'b1, 1'b0);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    pred_pc = pc_for(16);
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL collision_next_cycle: got %0b expected 1", pred_taken);
    end
    pred_pc = pc_for(17);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || int'(dut.ctr_q[17]) !== ctr_m[17]) begin
      failures++;
      $display("FAIL collision_neighbour: taken=%0b ctr=%0d expected 0/%0d", pred_taken, dut.ctr_q[17], ctr_m[17]);
    end
  endtask

  task automatic test_count_saturation();
    @(negedge clk);
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt;
    cnt_m = 64'hFFFF_FFFE;
    #1;
    checks++;
    if (mispredict_count !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL sat_preload: got %h expected fffffffe", mispredict_count);
    end
    for (int k = 0; k < 3; k++) begin
      drive_update(1'b1, 5, 1'b0);
      checks++;
      if (mispredict_count !== 32'hFFFF_FFFF || 64'(mispredict_count) !== cnt_m) begin
        failures++;
        $display("FAIL sat_count[%0d]: got %h expected ffffffff", k, mispredict_count);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int bad = 0;
    @(negedge clk);
    upd_valid = 1'b1;
    upd_idx   = 6'd16;
    upd_taken = 1'b1;
    upd_pred  = 1'b0;
    rst       = 1'b1;
    #1;
    checks++;
    if (mispredict_count !== 32'd0) begin
      failures++;
      $display("FAIL midreset_count: got %h expected 0", mispredict_count);
    end
    // sweep every entry while reset is held across clock edges with an update pending
    for (int i = 0; i < N; i++) begin
      pred_pc = 32'(i * 4);
      #1;
      if (pred_taken !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_all_entries: %0d entries predicted taken, expected 0", bad);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    pred_pc = 32'h40;
    #1;
    checks++;
    if (dut.ctr_q[16] !== 2'd0 || pred_taken !== 1'b0 || mispredict_count !== 32'd0) begin
      failures++;
      $display("FAIL midreset_update_dropped: ctr=%0d taken=%0b count=%0d expected 0/0/0",
               dut.ctr_q[16], pred_taken, mispredict_count);
    end
  endtask

  task automatic test_random();
    int bad_pred = 0;
    int bad_idx  = 0;
    int bad_cnt  = 0;
    for (int it = 0; it < 400; it++) begin
      logic [31:0] pc;
      int idx;
      int uidx;
      bit v, t, p;
      @(negedge clk);
      pc  = $urandom & 32'hFFFF_FF1F;
      idx = model_idx(pc);
      v   = bit'($urandom_range(0, 3) != 0);
      uidx = ($urandom_range(0, 1) == 1) ? idx : int'($urandom_range(0, 7));
      t   = bit'($urandom_range(0, 1));
      p   = ($urandom_range(0, 3) == 0) ? ~model_pred(uidx) : model_pred(uidx);
      pred_pc   = pc;
      upd_valid = v;
      upd_idx   = INDEX_BITS'(uidx);
      upd_taken = t;
      upd_pred  = p;
      #1;
      if (int'(pred_idx) !== idx) bad_idx++;
      if (pred_taken !== model_pred(idx)) bad_pred++;
      if (64'(mispredict_count) !== cnt_m) bad_cnt++;
      @(posedge clk);
      if (v) model_update(uidx, t, p);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    checks++;
    if (bad_idx != 0) begin
      failures++;
      $display("FAIL random_idx: %0d wrong indices, expected 0", bad_idx);
    end
    checks++;
    if (bad_pred != 0) begin
      failures++;
      $display("FAIL random_pred: %0d wrong predictions, expected 0", bad_pred);
    end
    checks++;
    if (bad_cnt != 0 || 64'(mispredict_count) !== cnt_m) begin
      failures++;
      $display("FAIL random_count: %0d mismatching cycles, final %0d expected %0d", bad_cnt, mispredict_count, cnt_m);
    end
  endtask

`ifdef BHT_GSHARE_EN
  task automatic test_gshare();
    apply_reset();
    for (int k = 0; k < 3; k++) drive_update(1'b1, 0, 1'b1);
    @(negedge clk);
    pred_pc = 32'h40;
    #1;
    checks++;
    if (ghr_out !== 6'b000111) begin
      failures++;
      $display("FAIL gshare_ghr: got %b expected 000111", ghr_out);
    end
    checks++;
    if (pred_idx !== 6'd23) begin
      failures++;
      $display("FAIL gshare_idx: got %0d expected 23", pred_idx);
    end
    drive_update(1'b1, 23, 1'b0);
    checks++;
    if (dut.ctr_q[16] !== 2'd0 || dut.ctr_q[23] !== 2'd1) begin
      failures++;
      $display("FAIL gshare_entry: ctr16=%0d ctr23=%0d expected 0/1", dut.ctr_q[16], dut.ctr_q[23]);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_train_taken();
    test_train_not_taken();
    test_collision();
    test_count_saturation();
    test_reset_midstream();
    test_random();
`ifdef BHT_GSHARE_EN
    test_gshare();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
